// File: rtl/dac_ctrl.sv
// dac_ctrl: serial write controller for a 12-bit / 16-bit-frame SPI-style DAC.
// Latches {RS1,SPD,PWR,RS0,Code} on a start strobe and shifts it out MSB-first.
// Ports:
//   clk, rst_n (async, active-low)
//   i_DAC_en (start strobe), i_DAC_Code[11:0], i_DAC_RS[1:0], i_DAC_SPD, i_DAC_PWR
//   o_DAC_DIN, o_DAC_SCLK (idles high), o_DAC_CS (active low), o_DAC_Done (1-clk pulse)
// Option: define DAC_CTRL_BUSY_EN to add o_DAC_Busy (high during SHIFT and STOP).
module dac_ctrl #(
  parameter int SCLK_HALF = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_DAC_en,
  input  logic [11:0] i_DAC_Code,
  input  logic [1:0]  i_DAC_RS,
  input  logic        i_DAC_SPD,
  input  logic        i_DAC_PWR,
  output logic        o_DAC_DIN,
  output logic        o_DAC_SCLK,
  output logic        o_DAC_CS,
  output logic        o_DAC_Done
`ifdef DAC_CTRL_BUSY_EN
  ,
  output logic        o_DAC_Busy
`endif
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCLK_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_STOP
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [4:0]    r_phase, w_phase;
  logic [15:0]   r_word, w_word;
  logic          r_din, w_din;
  logic          r_sclk, w_sclk;
  logic          r_cs, w_cs;
  logic          r_done, w_done;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_phase <= '0;
      r_word  <= '0;
      r_din   <= 1'b0;
      r_sclk  <= 1'b1;
      r_cs    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_phase <= w_phase;
      r_word  <= w_word;
      r_din   <= w_din;
      r_sclk  <= w_sclk;
      r_cs    <= w_cs;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_phase = r_phase;
    w_word  = r_word;
    w_din   = r_din;
    w_sclk  = r_sclk;
    w_cs    = r_cs;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_DAC_en) begin
          w_word  = {i_DAC_RS[1], i_DAC_SPD, i_DAC_PWR,
                     i_DAC_RS[0], i_DAC_Code};
          w_din   = i_DAC_RS[1];
          w_cs    = 1'b0;
          w_sclk  = 1'b1;
          w_cnt   = '0;
          w_phase = '0;
          w_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_cnt   = '0;
          w_phase = r_phase + 5'd1;
          // even phase = SCLK high, odd phase = SCLK low
          if (!r_phase[0]) begin
            w_sclk = 1'b0;
          end else begin
            w_sclk = 1'b1;
            if (r_phase == 5'd31) begin
              w_din   = 1'b0;
              w_state = S_STOP;
            end else begin
              // next bit goes out with the rising SCLK edge
              w_word = {r_word[14:0], 1'b0};
              w_din  = r_word[14];
            end
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_last) begin
          w_cnt   = '0;
          w_cs    = 1'b1;
          w_done  = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign o_DAC_DIN  = r_din;
  assign o_DAC_SCLK = r_sclk;
  assign o_DAC_CS   = r_cs;
  assign o_DAC_Done = r_done;
`ifdef DAC_CTRL_BUSY_EN
  assign o_DAC_Busy = (r_state != S_IDLE);
`endif

endmodule

// File: tb/tb_dac_ctrl.sv
// tb_dac_ctrl: directed bench for dac_ctrl with a word scoreboard.
// Frames are decoded from DIN on falling SCLK and compared to queued words.
module tb_dac_ctrl;

  localparam int H = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] code;
  logic [1:0]  rs;
  logic        spd;
  logic        pwr;
  logic        din;
  logic        sclk;
  logic        cs;
  logic        done;
`ifdef DAC_CTRL_BUSY_EN
  logic        busy;
`endif

  int          total;
  int          passed;
  logic [15:0] sb[$];

  dac_ctrl #(.SCLK_HALF(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_DAC_en   (en),
    .i_DAC_Code (code),
    .i_DAC_RS   (rs),
    .i_DAC_SPD  (spd),
    .i_DAC_PWR  (pwr),
    .o_DAC_DIN  (din),
    .o_DAC_SCLK (sclk),
    .o_DAC_CS   (cs),
    .o_DAC_Done (done)
`ifdef DAC_CTRL_BUSY_EN
    ,
    .o_DAC_Busy (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] word(input logic [11:0] c,
                                       input logic [1:0] r,
                                       input logic s,
                                       input logic p);
    return {r[1], s, p, r[0], c};
  endfunction

  task automatic start(input logic [11:0] c, input logic [1:0] r,
                       input logic s, input logic p);
    code = c;
    rs   = r;
    spd  = s;
    pwr  = p;
    en   = 1'b1;
    sb.push_back(word(c, r, s, p));
  endtask

  // Caller has driven en=1 before the edge that starts the frame (E0).
  task automatic frame(input int en_hold, input bit perturb,
                       input int abort_at);
    logic [15:0] got;
    logic [15:0] exp;
    logic        prev;
    int          falls;
    int          cslow;
    int          idx;
    int          bad;
    bit          seen;
    got   = '0;
    prev  = 1'b1;
    falls = 0;
    cslow = 0;
    idx   = -1;
    bad   = 0;
    seen  = 1'b0;
    exp   = sb.pop_front();
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("cs_fall", cs, 1'b0);
        chk("done_clr", done, 1'b0);
      end
      if (n == abort_at) begin
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("rst_cs", cs, 1'b1);
        chk("rst_sclk", sclk, 1'b1);
        chk("rst_din", din, 1'b0);
        chk("rst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_hold_done", done, 1'b0);
        chk("rst_hold_cs", cs, 1'b1);
        rst_n = 1'b1;
        return;
      end
      if (cs == 1'b0) cslow++;
      else if (sclk !== prev) bad++;
      if (prev && !sclk) begin
        got = {got[14:0], din};
        falls++;
      end
      prev = sclk;
`ifdef DAC_CTRL_BUSY_EN
      chk("busy", busy, !cs);
`endif
      if (done) begin
        seen = 1'b1;
        idx  = n;
      end
      en = (n + 1 < en_hold);
      if (perturb && n == 10) begin
        code = 12'hFFF;
        rs   = 2'b10;
      end
      if (perturb && n == 20) en = 1'b1;
    end
    chk("word", got, exp);
    chk("falls", falls, 16);
    chk("cs_low", cslow, 33 * H);
    chk("done_at", idx, 33 * H);
    chk("idle_sclk", bad, 0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    en     = 1'b0;
    code   = '0;
    rs     = '0;
    spd    = 1'b0;
    pwr    = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_cs", cs, 1'b1);
    chk("reset_sclk", sclk, 1'b1);
    chk("reset_din", din, 1'b0);
    chk("reset_done", done, 1'b0);
`ifdef DAC_CTRL_BUSY_EN
    chk("reset_busy", busy, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame, en two cycles
    start(12'hC9B, 2'b11, 1'b1, 1'b0);
    frame(2, 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("idle_cs", cs, 1'b1);
    chk("idle_sclk_hi", sclk, 1'b1);

    // en held 80 clocks: one frame, then one more from the Done edge
    start(12'h000, 2'b00, 1'b0, 1'b1);
    frame(80, 1'b0, -1);
    sb.push_back(word(12'h000, 2'b00, 1'b0, 1'b1));
    frame(80 - (33 * H + 1), 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("after_hold_cs", cs, 1'b1);

    // inputs change and en re-pulses mid-frame
    start(12'h5A3, 2'b01, 1'b0, 1'b0);
    frame(1, 1'b1, -1);
    repeat (3) @(negedge clk);
    chk("no_queue_cs", cs, 1'b1);

    // async reset at bit 8, then a clean frame
    start(12'hABC, 2'b10, 1'b1, 1'b1);
    frame(1, 1'b0, 16 * H + 2);
    @(negedge clk);
    start(12'h123, 2'b01, 1'b1, 1'b0);
    frame(1, 1'b0, -1);

    // back-to-back: en asserted during the Done cycle
    @(negedge clk);
    start(12'h7E5, 2'b11, 1'b0, 1'b1);
    frame(1, 1'b0, -1);
    start(12'h3C3, 2'b00, 1'b1, 1'b0);
    frame(1, 1'b0, -1);
    repeat (4) @(negedge clk);
    chk("end_cs", cs, 1'b1);
    chk("end_done", done, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
